// File: rtl/cofi_sched_pkg.sv
// cofi_sched shared types: request modes, FSM states and default thresholds.
// No ports; imported by the interface users, the width meter and the top.
package cofi_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_AUTO = 2'd2
    } cofi_mode_t;

    typedef enum logic {
        ST_OFF,
        ST_ON
    } cofi_state_t;

    localparam int WIDE_MIN_DEF = 300;
    localparam int STABLE_DEF   = 2;

endpackage

// File: rtl/cofi_sched_if.sv
// cofi_sched video/config bundle: pix_ce, hblank, vblank, req_mode in;
// blend_en, frame_width, width_valid, mode_change out. slave = scheduler side.
interface cofi_sched_if #(
    parameter int CNT_W = 10
) ();
    logic             pix_ce;
    logic             hblank;
    logic             vblank;
    logic [1:0]       req_mode;
    logic             blend_en;
    logic [CNT_W-1:0] frame_width;
    logic             width_valid;
    logic             mode_change;

    modport master (
        output pix_ce, hblank, vblank, req_mode,
        input  blend_en, frame_width, width_valid, mode_change
    );

    modport slave (
        input  pix_ce, hblank, vblank, req_mode,
        output blend_en, frame_width, width_valid, mode_change
    );
endinterface

// File: rtl/cofi_width_meter.sv
// Blank edge detect and active width measurement (line max, frame width).
// Ports: clk_i/rst_ni, pix_ce_i, hblank_i, vblank_i in; strobes, widths out.
module cofi_width_meter
    import cofi_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pix_ce_i,
    input  logic             hblank_i,
    input  logic             vblank_i,
    output logic             hb_rise_o,
    output logic             vb_rise_o,
    output logic [CNT_W-1:0] line_cnt_o,
    output logic [CNT_W-1:0] frame_w_next_o,
    output logic [CNT_W-1:0] frame_width_o,
    output logic             width_valid_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             hb_q, vb_q;
    logic [CNT_W-1:0] cnt_q, max_q, fw_q;
    logic             wv_q;

    assign hb_rise_o = pix_ce_i & hblank_i & ~hb_q;
    assign vb_rise_o = pix_ce_i & vblank_i & ~vb_q;

    // Includes a line still open when vblank arrives.
    assign frame_w_next_o = (cnt_q > max_q) ? cnt_q : max_q;

    assign line_cnt_o    = cnt_q;
    assign frame_width_o = fw_q;
    assign width_valid_o = wv_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hb_q  <= 1'b0;
            vb_q  <= 1'b0;
            cnt_q <= '0;
            max_q <= '0;
            fw_q  <= '0;
            wv_q  <= 1'b0;
        end else if (pix_ce_i) begin
            hb_q <= hblank_i;
            vb_q <= vblank_i;
            if (vb_rise_o) begin
                fw_q  <= frame_w_next_o;
                wv_q  <= 1'b1;
                max_q <= '0;
                cnt_q <= '0;
            end else if (hb_rise_o && !vblank_i) begin
                if (cnt_q > max_q) max_q <= cnt_q;
                cnt_q <= '0;
            end else if (!hblank_i && !vblank_i && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cofi_sched.sv
// Blend enable scheduler: frame-synchronous off/on/auto decision.
// Ports: clk, reset_n, bus (cofi_sched_if.slave). Option: COFI_SCHED_LINE_SWITCH_EN.
module cofi_sched
    import cofi_pkg::*;
#(
    parameter int CNT_W         = 10,
    parameter int WIDE_MIN      = WIDE_MIN_DEF,
    parameter int STABLE_FRAMES = STABLE_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    cofi_sched_if.slave    bus
);
    localparam logic [3:0]  STAB_MAX = 4'(STABLE_FRAMES);
    localparam logic [31:0] WIDE_THR = WIDE_MIN;

    logic             hb_rise, vb_rise;
    logic [CNT_W-1:0] line_cnt, frame_w_next, frame_width;
    logic             width_valid;

    cofi_width_meter #(.CNT_W(CNT_W)) u_meter (
        .clk_i          (clk),
        .rst_ni         (reset_n),
        .pix_ce_i       (bus.pix_ce),
        .hblank_i       (bus.hblank),
        .vblank_i       (bus.vblank),
        .hb_rise_o      (hb_rise),
        .vb_rise_o      (vb_rise),
        .line_cnt_o     (line_cnt),
        .frame_w_next_o (frame_w_next),
        .frame_width_o  (frame_width),
        .width_valid_o  (width_valid)
    );

    cofi_state_t state_q, state_d;
    logic [3:0]  stab_q, stab_next;
    logic        last_wide_q;
    logic        mode_change_q;
    logic        wide;

    assign wide = {{(32-CNT_W){1'b0}}, frame_w_next} >= WIDE_THR;

    always_comb begin
        stab_next = 4'd1;
        if (wide == last_wide_q)
            stab_next = (stab_q >= STAB_MAX) ? STAB_MAX : stab_q + 4'd1;
    end

`ifdef COFI_SCHED_LINE_SWITCH_EN
    logic line_wide;
    assign line_wide = {{(32-CNT_W){1'b0}}, line_cnt} >= WIDE_THR;
`else
    logic unused_line;
    assign unused_line = ^{hb_rise, line_cnt};
`endif

    always_comb begin
        state_d = state_q;
        if (vb_rise) begin
            unique case (1'b1)
                bus.req_mode == MODE_ON:
                    state_d = ST_ON;
                bus.req_mode == MODE_AUTO:
                    if (stab_next >= STAB_MAX)
                        state_d = wide ? ST_ON : ST_OFF;
                default:
                    state_d = ST_OFF;
            endcase
        end
`ifdef COFI_SCHED_LINE_SWITCH_EN
        // Unfiltered per-line decision for mid-frame resolution switches.
        else if (hb_rise && !bus.vblank && bus.req_mode == MODE_AUTO) begin
            state_d = line_wide ? ST_ON : ST_OFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_OFF;
            stab_q        <= 4'd0;
            last_wide_q   <= 1'b0;
            mode_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_change_q <= (state_d != state_q);
            if (vb_rise) begin
                stab_q      <= stab_next;
                last_wide_q <= wide;
            end
        end
    end

    assign bus.blend_en    = (state_q == ST_ON);
    assign bus.mode_change = mode_change_q;
    assign bus.frame_width = frame_width;
    assign bus.width_valid = width_valid;
endmodule

// File: tb/tb_cofi_sched.sv
// Scoreboard bench for cofi_sched: directed frames, per-vblank response check.
// Expected outputs are pushed per frame and popped one clk after vblank rises.
module tb_cofi_sched;
    import cofi_pkg::*;

    typedef struct {
        bit bl;
        int fw;
        bit mc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cofi_sched_if #(.CNT_W(10)) bus ();

    cofi_sched #(
        .CNT_W(10),
        .WIDE_MIN(300),
        .STABLE_FRAMES(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   stray  = 0;
    bit   cur_bl = 1'b0;
    bit   vbp    = 1'b0;
    bit   fire   = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    // Bench-side vblank rise detector, qualified by pix_ce.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vbp  <= 1'b0;
            fire <= 1'b0;
        end else begin
            fire <= bus.pix_ce && bus.vblank && !vbp;
            if (bus.pix_ce) vbp <= bus.vblank;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (fire) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vblank actual=1 required=0");
            end else begin
                e = q.pop_front();
                chk("blend_en", int'(bus.blend_en), int'(e.bl));
                chk("frame_width", int'(bus.frame_width), e.fw);
                chk("width_valid", int'(bus.width_valid), 1);
                chk("mode_change", int'(bus.mode_change), int'(e.mc));
            end
        end else if (reset_n && bus.mode_change) begin
            stray++;
        end
    end

    task automatic px(input logic h, input logic v);
        @(negedge clk);
        bus.hblank = h;
        bus.vblank = v;
        bus.pix_ce = 1'b1;
        @(negedge clk);
        bus.pix_ce = 1'b0;
    endtask

    task automatic line(input int n, input bit term);
        for (int i = 0; i < n; i++) px(1'b0, 1'b0);
        if (term)
            for (int i = 0; i < 4; i++) px(1'b1, 1'b0);
    endtask

    task automatic frame(
        input int w1, input int w2, input int w3,
        input bit fold, input bit mid_chg, input logic [1:0] mid_mode,
        input bit ebl, input int efw, input bit emc
    );
        exp_t e;
        e.bl = ebl;
        e.fw = efw;
        e.mc = emc;
        q.push_back(e);
        line(w1, 1'b1);
        if (mid_chg) begin
            bus.req_mode = mid_mode;
            for (int i = 0; i < 3; i++) px(1'b1, 1'b0);
            chk("midframe_hold", int'(bus.blend_en), int'(cur_bl));
        end
        line(w2, 1'b1);
        line(w3, !fold);
        for (int i = 0; i < 3; i++) px(1'b1, 1'b1);
        cur_bl = ebl;
    endtask

    initial begin
        bus.pix_ce   = 1'b0;
        bus.hblank   = 1'b0;
        bus.vblank   = 1'b0;
        bus.req_mode = 2'd2;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_blend_en", int'(bus.blend_en), 0);
        chk("rst_frame_width", int'(bus.frame_width), 0);
        chk("rst_width_valid", int'(bus.width_valid), 0);
        chk("rst_mode_change", int'(bus.mode_change), 0);

        frame(320, 320, 320, 0, 0, 2'd0, 0, 320, 0);
        frame(320, 320, 320, 0, 0, 2'd0, 1, 320, 1);
        frame(320, 320, 320, 0, 0, 2'd0, 1, 320, 0);
        frame(256, 256, 256, 0, 0, 2'd0, 1, 256, 0);
        frame(256, 256, 256, 0, 0, 2'd0, 0, 256, 1);

        bus.req_mode = 2'd0;
        frame(256, 256, 256, 0, 0, 2'd0, 0, 256, 0);
        frame(256, 256, 256, 0, 1, 2'd1, 1, 256, 1);
        frame(256, 320, 256, 0, 0, 2'd0, 1, 320, 0);
        frame(1100, 10, 10, 0, 0, 2'd0, 1, 1023, 0);
        frame(256, 256, 330, 1, 0, 2'd0, 1, 330, 0);

        bus.req_mode = 2'd2;
        frame(320, 320, 320, 0, 0, 2'd0, 1, 320, 0);

        line(100, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_blend_en", int'(bus.blend_en), 0);
        chk("async_frame_width", int'(bus.frame_width), 0);
        chk("async_width_valid", int'(bus.width_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cur_bl = 1'b0;

        frame(200, 320, 320, 0, 0, 2'd0, 0, 320, 0);
        frame(320, 320, 320, 0, 0, 2'd0, 1, 320, 1);

        repeat (6) px(1'b0, 1'b0);
        chk("queue_drained", q.size(), 0);
        chk("stray_mode_change", stray, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
